// File: rtl/signal_delay_line.sv
// Run-time programmable delay line: 0..MAX_DEPTH enabled cycles of latency for a
// valid-qualified data stream, with stall, flush-on-delay-change and a primed flag.
module signal_delay_line #(
    parameter int                 WIDTH     = 10,
    parameter int                 MAX_DEPTH = 8,
    parameter int                 DEPTH_W   = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DEPTH_W-1:0] delay_sel,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_signal,
    output logic [WIDTH-1:0]   out_signal,
    output logic               out_valid,
    output logic               primed,
    output logic [DEPTH_W-1:0] delay_cur
);

    localparam logic [DEPTH_W-1:0] MAX_SEL = DEPTH_W'(MAX_DEPTH);

    // Streaming, valid-only: there is no backpressure. in_valid qualifies in_signal
    // at every enabled edge, and out_valid qualifies out_signal every cycle.
    logic [WIDTH-1:0]     data_q [MAX_DEPTH];
    logic [WIDTH-1:0]     data_d [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] valid_q;
    logic [MAX_DEPTH-1:0] valid_d;
    logic [DEPTH_W-1:0]   fill_q;
    logic [DEPTH_W-1:0]   fill_d;
    logic [DEPTH_W-1:0]   delay_q;
    logic [DEPTH_W-1:0]   delay_d;
    logic [DEPTH_W-1:0]   sel_clamped;
    logic                 flush;

    always_comb begin
        sel_clamped = (delay_sel > MAX_SEL) ? MAX_SEL : delay_sel;
        flush       = (sel_clamped != delay_q);
    end

    // A flush drops the edge's sample and only clears valids; data bits are kept.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fill_d  = fill_q;
        delay_d = delay_q;
        if (flush) begin
            delay_d = sel_clamped;
            valid_d = '0;
            fill_d  = '0;
        end else if (en) begin
            data_d[0]  = in_signal;
            valid_d[0] = in_valid;
            for (int k = 1; k < MAX_DEPTH; k++) begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
            if (fill_q != MAX_SEL) begin
                fill_d = fill_q + DEPTH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < MAX_DEPTH; k++) begin
                data_q[k] <= RESET_VAL;
            end
            valid_q <= '0;
            fill_q  <= '0;
            delay_q <= sel_clamped;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fill_q  <= fill_d;
            delay_q <= delay_d;
        end
    end

    // Delay 0 is a pure combinational bypass; otherwise tap stage delay_q-1.
    always_comb begin
        out_signal = in_signal;
        out_valid  = in_valid;
        for (int k = 0; k < MAX_DEPTH; k++) begin
            if (delay_q == DEPTH_W'(k + 1)) begin
                out_signal = data_q[k];
                out_valid  = valid_q[k];
            end
        end
        primed    = (delay_q == '0) ? rst : (fill_q >= delay_q);
        delay_cur = delay_q;
    end

endmodule
